// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the synchronous RAM controller and its storage array.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_word,
    input logic [MERGE_W-1:0]   new_word,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_W/8; i++)
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Single-port storage with byte-enable writes and a registered read port.
module sync_ram_array
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array: contents survive rst unless the clear sequence overwrites them.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= DATA_W'(byte_merge(MERGE_W'(mem[addr]), MERGE_W'(wdata), (MERGE_W/8)'(be)));
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request/response front end for sync_ram_array: clear-on-reset sequencer,
// request gating and the RD_LAT-deep read response pipeline.
module sync_ram_ctrl
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_en,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic [BE_W-1:0]   byte_en,
  output logic              req_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rsp_valid,
  output logic              init_done
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              ready_q;
  logic              clr_we;
  logic              acc, acc_rd, acc_wr;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;

  logic [RD_LAT:0]   vld_pipe;
  logic [RD_LAT:1]   vld_q;
  logic [DATA_W-1:0] rsp_data;

  // Nothing is accepted on a reset edge, so a request cannot sneak in alongside rst.
  assign acc    = chip_en && ready_q && !rst;
  assign acc_rd = acc && (read_write == OP_READ);
  assign acc_wr = acc && (read_write == OP_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ready_q <= (state_nxt == READY);
    end
  end

  // Terminal count holds the counter so the clear never makes a second pass.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = !rst;
        if (clr_cnt == '1) state_nxt = READY;
        else               clr_cnt_nxt = clr_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign arr_we    = clr_we || acc_wr;
  assign arr_addr  = clr_we ? clr_cnt : address;
  assign arr_wdata = clr_we ? '0 : data_in;
  assign arr_be    = clr_we ? '1 : byte_en;

  sync_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (acc_rd),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  assign vld_pipe = {vld_q, acc_rd};

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[RD_LAT-1:0];
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rsp_data = arr_rdata;
    end else begin : g_lat2
      logic [DATA_W-1:0] data_q;
      always_ff @(posedge clk)
        if (vld_pipe[1]) data_q <= arr_rdata;
      assign rsp_data = data_q;
    end
  endgenerate

  assign rsp_valid = vld_pipe[RD_LAT];
  assign data_out  = vld_pipe[RD_LAT] ? rsp_data : '0;
  assign req_ready = ready_q;
  assign init_done = ready_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed and random tests for sync_ram_ctrl at RD_LAT=1 and RD_LAT=2 against a cycle model.
module tb_sync_ram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int BW    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chip_en = 1'b0;
  logic          read_write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] byte_en = '0;

  logic          rdy1, rv1, done1, rdy2, rv2, done2;
  logic [DW-1:0] do1, do2;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;

  always #5 clk = ~clk;

  sync_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .chip_en(chip_en), .read_write(read_write), .address(address),
    .data_in(data_in), .byte_en(byte_en), .req_ready(rdy1), .data_out(do1),
    .rsp_valid(rv1), .init_done(done1));

  sync_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .chip_en(chip_en), .read_write(read_write), .address(address),
    .data_in(data_in), .byte_en(byte_en), .req_ready(rdy2), .data_out(do2),
    .rsp_valid(rv2), .init_done(done2));

  // Reference model: memory contents, ready flag, and responses due at a given edge.
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  logic [DW-1:0] mmem [DEPTH];
  bit   m_ready = 1'b0;
  int   m_clr   = 0;
  int   edge_n  = 0;
  rsp_t q1[$];
  rsp_t q2[$];

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_ready = 1'b0;
      m_clr   = 0;
      q1.delete();
      q2.delete();
    end else if (!m_ready) begin
      mmem[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_ready = 1'b1;
    end else if (chip_en) begin
      if (read_write) begin
        for (int b = 0; b < BW; b++)
          if (byte_en[b]) mmem[address][8*b +: 8] = data_in[8*b +: 8];
      end else begin
        q1.push_back('{due: edge_n,     d: mmem[address]});
        q2.push_back('{due: edge_n + 1, d: mmem[address]});
      end
    end
  end

  bit            e1v, e2v;
  logic [DW-1:0] e1d, e2d;

  always @(negedge clk) begin
    if (sb_en) begin
      while (q1.size() != 0 && q1[0].due < edge_n) void'(q1.pop_front());
      while (q2.size() != 0 && q2[0].due < edge_n) void'(q2.pop_front());
      e1v = (q1.size() != 0 && q1[0].due == edge_n);
      e2v = (q2.size() != 0 && q2[0].due == edge_n);
      e1d = e1v ? q1[0].d : '0;
      e2d = e2v ? q2[0].d : '0;
      if (e1v) void'(q1.pop_front());
      if (e2v) void'(q2.pop_front());
      checks++;
      if (rv1 !== e1v || do1 !== e1d) begin
        errors++;
        $display("FAIL sb_rsp_lat1 t=%0t got v=%b d=%h exp v=%b d=%h", $time, rv1, do1, e1v, e1d);
      end
      checks++;
      if (rv2 !== e2v || do2 !== e2d) begin
        errors++;
        $display("FAIL sb_rsp_lat2 t=%0t got v=%b d=%h exp v=%b d=%h", $time, rv2, do2, e2v, e2d);
      end
      checks++;
      if (rdy1 !== m_ready || done1 !== m_ready || rdy2 !== m_ready || done2 !== m_ready) begin
        errors++;
        $display("FAIL sb_ready t=%0t got rdy=%b%b done=%b%b exp %b", $time, rdy1, rdy2, done1, done2, m_ready);
      end
    end
  end

  // Stimulus primitives: drive at a falling edge, return at the next falling edge.
  task automatic op(input logic r, input logic ce, input logic rw, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [BW-1:0] be);
    rst = r; chip_en = ce; read_write = rw; address = a; data_in = d; byte_en = be;
    @(negedge clk);
  endtask

  task automatic idle();                                                   op(1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic do_reset();                                               op(1'b1, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be); op(1'b0, 1'b1, 1'b1, a, d, be); endtask
  task automatic rd(input logic [AW-1:0] a);                               op(1'b0, 1'b1, 1'b0, a, '0, '0); endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (rdy1 !== 1'b0 || done1 !== 1'b0 || rv1 !== 1'b0 || do1 !== '0 || rdy2 !== 1'b0 || rv2 !== 1'b0 || do2 !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b done=%b rv=%b%b do=%h/%h exp all 0", rdy1, done1, rv1, rv2, do1, do2);
    end
    n = 0;
    while (!rdy1 && n < 64) begin idle(); n++; end
    checks++;
    if (n != DEPTH || done1 !== 1'b1 || rdy2 !== 1'b1) begin
      errors++;
      $display("FAIL clear_duration got %0d cycles done=%b exp %0d cycles done=1", n, done1, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      checks++;
      if (rv1 !== 1'b1 || do1 !== 16'h0000) begin
        errors++;
        $display("FAIL clear_readback addr=%0d got v=%b d=%h exp v=1 d=0000", a, rv1, do1);
      end
    end
    idle(); idle();
  endtask

  task automatic test_gating();
    int n;
    do_reset();
    n = 0;
    while (!rdy1 && n < 64) begin op(1'b0, 1'b1, 1'b1, 4'd5, 16'hFFFF, 2'b11); n++; end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL gating_clear_len got %0d exp %0d", n, DEPTH);
    end
    rd(4'd5);
    checks++;
    if (rv1 !== 1'b1 || do1 !== 16'h0000) begin
      errors++;
      $display("FAIL gating_addr5 got v=%b d=%h exp v=1 d=0000", rv1, do1);
    end
    idle(); idle();
  endtask

  task automatic test_byte_en();
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    checks++;
    if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rsp got rv=%b%b exp 00", rv1, rv2);
    end
    rd(4'd3);
    checks++;
    if (rv1 !== 1'b1 || do1 !== 16'hAB34 || rv2 !== 1'b0 || do2 !== '0) begin
      errors++;
      $display("FAIL byte_en_lat1 got v=%b d=%h / v2=%b d2=%h exp 1 ab34 / 0 0000", rv1, do1, rv2, do2);
    end
    idle();
    checks++;
    if (rv1 !== 1'b0 || do1 !== '0 || rv2 !== 1'b1 || do2 !== 16'hAB34) begin
      errors++;
      $display("FAIL byte_en_lat2 got v=%b d=%h / v2=%b d2=%h exp 0 0000 / 1 ab34", rv1, do1, rv2, do2);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(16'h0010 + i), 2'b11);
    checks++;
    if (rv2 !== 1'b0 || do2 !== '0) begin
      errors++;
      $display("FAIL b2b_before got v=%b d=%h exp 0 0000", rv2, do2);
    end
    for (int i = 0; i < 4; i++) begin
      rd(AW'(i));
      checks++;
      if (rv1 !== 1'b1 || do1 !== DW'(16'h0010 + i) ||
          rv2 !== (i != 0) || do2 !== ((i == 0) ? 16'h0000 : DW'(16'h0010 + i - 1))) begin
        errors++;
        $display("FAIL b2b_rd%0d got v=%b d=%h / v2=%b d2=%h", i, rv1, do1, rv2, do2);
      end
    end
    idle();
    checks++;
    if (rv2 !== 1'b1 || do2 !== 16'h0013 || rv1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last got v2=%b d2=%h v1=%b exp 1 0013 0", rv2, do2, rv1);
    end
    idle();
    checks++;
    if (rv2 !== 1'b0 || do2 !== '0) begin
      errors++;
      $display("FAIL b2b_after got v=%b d=%h exp 0 0000", rv2, do2);
    end
  endtask

  task automatic test_hazard();
    wr(4'd7, 16'h5555, 2'b11);
    rd(4'd7);
    checks++;
    if (rv1 !== 1'b1 || do1 !== 16'h5555) begin
      errors++;
      $display("FAIL hazard_lat1 got v=%b d=%h exp 1 5555", rv1, do1);
    end
    idle();
    checks++;
    if (rv2 !== 1'b1 || do2 !== 16'h5555) begin
      errors++;
      $display("FAIL hazard_lat2 got v=%b d=%h exp 1 5555", rv2, do2);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n, stray;
    wr(4'd1, 16'h1111, 2'b11);
    rd(4'd1);
    rd(4'd2);
    do_reset();
    checks++;
    if (rv1 !== 1'b0 || rv2 !== 1'b0 || do1 !== '0 || do2 !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush got rv=%b%b do=%h/%h exp 00 0000/0000", rv1, rv2, do1, do2);
    end
    n = 0; stray = 0;
    while (!rdy1 && n < 64) begin
      idle(); n++;
      if (rv1 || rv2) stray++;
    end
    checks++;
    if (n != DEPTH || stray != 0) begin
      errors++;
      $display("FAIL reset_mid_clear got %0d cycles %0d pulses exp %0d cycles 0 pulses", n, stray, DEPTH);
    end
    rd(4'd1);
    checks++;
    if (rv1 !== 1'b1 || do1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_addr1 got v=%b d=%h exp 1 0000", rv1, do1);
    end
    idle(); idle();
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else op(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom), BW'($urandom));
    end
    n = 0;
    while (!rdy1 && n < 64) begin idle(); n++; end
    checks++;
    if (!rdy1) begin
      errors++;
      $display("FAIL random_ready got rdy=%b after %0d cycles exp 1", rdy1, n);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      checks++;
      if (rv1 !== 1'b1 || do1 !== mmem[a]) begin
        errors++;
        $display("FAIL random_final addr=%0d got v=%b d=%h exp 1 %h", a, rv1, do1, mmem[a]);
      end
    end
    idle(); idle();
  endtask

  initial begin
    sb_en = 1'b1;
    test_reset();
    test_gating();
    test_byte_en();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_random();
    sb_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ram_ctrl.md
Name: sync_ram_ctrl

Overview:
Parametrised synchronous single-port RAM with a request/response handshake, per-byte write enables, configurable read latency and a hardware clear-on-reset sequencer. It replaces the fixed 256x8 combinational-read memory used in the design. Register-file and buffer clients sit upstream of it and issue one request per cycle.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W words
DATA_W, 8, word width; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width; derived, not overridden
RD_LAT, 1, read latency in cycles from acceptance to response; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined after reset

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
chip_en  in  1  request valid
read_write  in  1  1 = write, 0 = read
address  in  ADDR_W  word address
data_in  in  DATA_W  write data
byte_en  in  BE_W  write byte enables; bit i controls data_in[8i+7:8i]; ignored for reads
req_ready  out  1  request can be accepted this cycle
data_out  out  DATA_W  read data; 0 whenever rsp_valid = 0
rsp_valid  out  1  data_out carries a read response this cycle
init_done  out  1  clear sequence finished; stays high until the next rst

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: req_ready 0, data_out 0, rsp_valid 0, init_done 0. The read pipeline is flushed and the clear counter is set to 0.
- States: CLEAR and READY.
  - After rst, go to CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
- CLEAR:
  - Writes 0 to address clr_cnt each cycle; clr_cnt increments from 0.
  - req_ready = 0; chip_en is ignored.
  - On the cycle that clears address 2**ADDR_W-1, the next state is READY, with init_done = 1 and req_ready = 1 from that next cycle.
  - Duration is exactly 2**ADDR_W cycles.
  - The terminal count is detected explicitly; the counter must not wrap back into a second pass.
- READY:
  - req_ready = 1 and init_done = 1. With CLEAR_ON_RESET = 0, init_done rises together with req_ready in the first cycle after reset deasserts.
  - Accept: chip_en && req_ready at a rising edge.
  - Write: bytes with byte_en[i] = 1 update at that edge. A write with byte_en = 0 is accepted and changes nothing. No response is generated.
  - Read: rsp_valid = 1 and data_out = mem[address] exactly RD_LAT cycles after the acceptance edge, for one cycle only.
  - Fully pipelined: one read per cycle, back-to-back responses. There is no response backpressure.
  - Response data reflects all writes accepted before the read. A write followed by a read of the same address in the next cycle returns the new data.
  - Only one request per cycle (single port). Read and write in the same cycle are impossible by construction.
  - Out-of-range addressing cannot occur: address spans the full depth.
- rst asserted mid-operation (CLEAR or in-flight reads):
  - At the next edge, all in-flight responses are discarded and rsp_valid/data_out become 0.
  - The clear sequence restarts at address 0.
  - Writes already accepted remain in the array unless the clear overwrites them.
- chip_en while req_ready = 0 has no effect and is never queued.

Decomposition:
- Package sync_ram_pkg holds:
  - the state enum typedef (CLEAR, READY);
  - localparams OP_READ = 1'b0 and OP_WRITE = 1'b1;
  - a function for byte-merge of data_in/byte_en into the old word.
- Sub-module sync_ram_array: storage plus a registered read port with byte-enable write. sync_ram_ctrl keeps the FSM, clear counter and RD_LAT valid/data pipeline.

Test Plan:
- Reset then clear (ADDR_W=4, DATA_W=16, CLEAR_ON_RESET=1): pulse rst 1 cycle -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; reading all 16 addresses returns 0x0000.
- Byte-enable write: write 0xABCD to addr 3 with byte_en=2'b11, then 0x1234 with byte_en=2'b01, then read addr 3 -> data_out=0xAB34 with rsp_valid exactly RD_LAT cycles after acceptance.
- Back-to-back reads, RD_LAT=2: write addr 0..3 = 0x0010..0x0013, then read 0,1,2,3 on consecutive cycles -> rsp_valid high for 4 consecutive cycles carrying 0x0010..0x0013 in order; data_out=0 before and after.
- Write-then-read hazard: write 0x5555 to addr 7, read addr 7 in the next cycle -> 0x5555.
- Reset mid-stream: issue reads to addr 1 and 2, then assert rst before the responses return -> no rsp_valid pulse, the clear restarts, and after 16 cycles addr 1 reads 0x0000.
- Gating: chip_en=1, read_write=1, data 0xFFFF to addr 5 during CLEAR -> ignored; addr 5 reads 0x0000 after init_done.
